// File: rtl/cia_bus_pkg.sv
// cia_bus_pkg
//   Shared definitions for the CIA bus arbiter slice:
//   - state_t   : arbiter FSM states
//   - REQ_*     : requester indices (0 = 6502 CPU bridge, 1 = debug/host port)
//   - CIA_*     : mos6526 register-select addresses
package cia_bus_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_PHI2 = 3'd1,
      ACCESS    = 3'd2,
      CAPTURE   = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic REQ_CPU  = 1'b0;
   localparam logic REQ_HOST = 1'b1;

   localparam logic [3:0] CIA_PRA   = 4'h0;
   localparam logic [3:0] CIA_PRB   = 4'h1;
   localparam logic [3:0] CIA_DDRA  = 4'h2;
   localparam logic [3:0] CIA_DDRB  = 4'h3;
   localparam logic [3:0] CIA_TA_LO = 4'h4;
   localparam logic [3:0] CIA_TA_HI = 4'h5;
   localparam logic [3:0] CIA_TB_LO = 4'h6;
   localparam logic [3:0] CIA_TB_HI = 4'h7;
   localparam logic [3:0] CIA_ICR   = 4'hd;
   localparam logic [3:0] CIA_CRA   = 4'he;
   localparam logic [3:0] CIA_CRB   = 4'hf;

endpackage

// File: rtl/cia_rr_pick.sv
// cia_rr_pick
//   Combinational 2-way winner selection for the CIA bus arbiter.
//   Ports:
//     i_req       [1:0] pending requests (bit n = requester n)
//     i_last            requester served most recently
//     i_lock_hold       last-served requester holds a lock
//     i_lock_id         requester owning the lock
//     o_gnt             winning requester index
//     o_vld             a winner exists
//   RR_EN = 1 alternates on a tie (the requester not served last wins);
//   RR_EN = 0 gives requester 0 fixed priority.
module cia_rr_pick
   import cia_bus_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_lock_hold,
   input  logic       i_lock_id,
   output logic       o_gnt,
   output logic       o_vld
);

   always_comb begin
      o_gnt = REQ_CPU;
      o_vld = 1'b0;
      if (i_lock_hold) begin
         // A held lock excludes the other requester entirely, even if the
         // owner is not requesting right now.
         o_gnt = i_lock_id;
         o_vld = i_req[i_lock_id];
      end else begin
         case (i_req)
            2'b01: begin
               o_gnt = REQ_CPU;
               o_vld = 1'b1;
            end
            2'b10: begin
               o_gnt = REQ_HOST;
               o_vld = 1'b1;
            end
            2'b11: begin
               o_gnt = RR_EN ? ~i_last : REQ_CPU;
               o_vld = 1'b1;
            end
            default: begin
               o_gnt = REQ_CPU;
               o_vld = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cia_bus_arbiter.sv
// cia_bus_arbiter
//   Shares the mos6526 register port between requester 0 (CPU bridge) and
//   requester 1 (debug/host). Each grant becomes one phi2-aligned chip-select
//   cycle; read data is captured and returned with a one-clock ack.
//   Ports:
//     clk, reset             system clock, synchronous active-high reset
//     phi2                   one-clk CIA bus-phase strobe
//     rN_req/we/rs/wdata     requester N access request and payload
//     rN_lock                keep the grant for requester N's next access
//     rN_ack, rN_rdata       completion pulse and read data (held after ack)
//     cia_cs_n/rw/rs/wdata   registered drive to the mos6526 pins
//     cia_rdata              mos6526 db_out
//   Timing (req and phi2 sampled at edge k): cs_n low k..k+1, ack k+2..k+3,
//   back in IDLE at k+3, next arbitration at k+4.
module cia_bus_arbiter
   import cia_bus_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       phi2,
   input  logic       r0_req,
   input  logic       r0_we,
   input  logic [3:0] r0_rs,
   input  logic [7:0] r0_wdata,
   input  logic       r0_lock,
   output logic       r0_ack,
   output logic [7:0] r0_rdata,
   input  logic       r1_req,
   input  logic       r1_we,
   input  logic [3:0] r1_rs,
   input  logic [7:0] r1_wdata,
   input  logic       r1_lock,
   output logic       r1_ack,
   output logic [7:0] r1_rdata,
   output logic       cia_cs_n,
   output logic       cia_rw,
   output logic [3:0] cia_rs,
   output logic [7:0] cia_wdata,
   input  logic [7:0] cia_rdata
);

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_gnt;
   logic       r_lock;
   logic       r_last;
   logic       r_lock_hold;
   logic       r_cs_n;
   logic       r_rw;
   logic [3:0] r_rs;
   logic [7:0] r_wdata;
   logic       r_ack0;
   logic       r_ack1;
   logic [7:0] r_rdata0;
   logic [7:0] r_rdata1;

   logic       w_pick_gnt;
   logic       w_pick_vld;
   logic       w_load;
   logic       w_cs_fall;
   logic       w_cs_rise;
   logic       w_capture;
   logic       w_finish;

   // The lock owner is always the last-served requester.
   cia_rr_pick #(
      .RR_EN (RR_EN)
   ) u_pick (
      .i_req       ({r1_req, r0_req}),
      .i_last      (r_last),
      .i_lock_hold (r_lock_hold),
      .i_lock_id   (r_last),
      .o_gnt       (w_pick_gnt),
      .o_vld       (w_pick_vld)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_cs_fall   = 1'b0;
      w_cs_rise   = 1'b0;
      w_capture   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_load = 1'b1;
               if (phi2) begin
                  w_state_nxt = ACCESS;
                  w_cs_fall   = 1'b1;
               end else begin
                  w_state_nxt = WAIT_PHI2;
               end
            end
         end
         WAIT_PHI2: begin
            if (phi2) begin
               w_state_nxt = ACCESS;
               w_cs_fall   = 1'b1;
            end
         end
         ACCESS: begin
            w_state_nxt = CAPTURE;
            w_cs_rise   = 1'b1;
         end
         CAPTURE: begin
            w_state_nxt = DONE;
            w_capture   = 1'b1;
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_finish    = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt       <= REQ_CPU;
         r_lock      <= 1'b0;
         r_last      <= REQ_HOST;
         r_lock_hold <= 1'b0;
         r_cs_n      <= 1'b1;
         r_rw        <= 1'b1;
         r_rs        <= '0;
         r_wdata     <= '0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         // The whole request, lock included, is taken at grant; later changes
         // on the requester's inputs do not affect the access in flight.
         if (w_load) begin
            r_gnt   <= w_pick_gnt;
            r_lock  <= w_pick_gnt ? r1_lock : r0_lock;
            r_rw    <= w_pick_gnt ? ~r1_we : ~r0_we;
            r_rs    <= w_pick_gnt ? r1_rs : r0_rs;
            r_wdata <= w_pick_gnt ? r1_wdata : r0_wdata;
         end
         if (w_cs_fall) begin
            r_cs_n <= 1'b0;
         end else if (w_cs_rise) begin
            r_cs_n <= 1'b1;
         end
         r_ack0 <= w_capture & (r_gnt == REQ_CPU);
         r_ack1 <= w_capture & (r_gnt == REQ_HOST);
         if (w_capture && r_rw) begin
            if (r_gnt == REQ_HOST) begin
               r_rdata1 <= cia_rdata;
            end else begin
               r_rdata0 <= cia_rdata;
            end
         end
         if (w_finish) begin
            r_last      <= r_gnt;
            r_lock_hold <= r_lock;
         end
      end
   end

   assign r0_ack    = r_ack0;
   assign r1_ack    = r_ack1;
   assign r0_rdata  = r_rdata0;
   assign r1_rdata  = r_rdata1;
   assign cia_cs_n  = r_cs_n;
   assign cia_rw    = r_rw;
   assign cia_rs    = r_rs;
   assign cia_wdata = r_wdata;

endmodule

// File: tb/tb_cia_bus_arbiter.sv
module tb_cia_bus_arbiter;
   import cia_bus_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       phi2 = 1'b0;
   logic       r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
   logic [3:0] r0_rs = '0;
   logic [7:0] r0_wdata = '0;
   logic       r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
   logic [3:0] r1_rs = '0;
   logic [7:0] r1_wdata = '0;
   logic [7:0] cia_out = '0;

   // round-robin instance (rr_*) and fixed-priority instance (fp_*)
   logic       rr_r0_ack, rr_r1_ack, rr_cs_n, rr_rw;
   logic [7:0] rr_r0_rdata, rr_r1_rdata, rr_wdata;
   logic [3:0] rr_rs;
   logic       fp_r0_ack, fp_r1_ack, fp_cs_n, fp_rw;
   logic [7:0] fp_r0_rdata, fp_r1_rdata, fp_wdata;
   logic [3:0] fp_rs;

   logic       sel = 1'b0;  // 0: observe rr instance, 1: observe fp instance
   logic       s_r0_ack, s_r1_ack, s_cs_n, s_rw;
   logic [7:0] s_r0_rdata, s_r1_rdata, s_wdata;
   logic [3:0] s_rs;

   assign s_r0_ack   = sel ? fp_r0_ack   : rr_r0_ack;
   assign s_r1_ack   = sel ? fp_r1_ack   : rr_r1_ack;
   assign s_r0_rdata = sel ? fp_r0_rdata : rr_r0_rdata;
   assign s_r1_rdata = sel ? fp_r1_rdata : rr_r1_rdata;
   assign s_cs_n     = sel ? fp_cs_n     : rr_cs_n;
   assign s_rw       = sel ? fp_rw       : rr_rw;
   assign s_rs       = sel ? fp_rs       : rr_rs;
   assign s_wdata    = sel ? fp_wdata    : rr_wdata;

   cia_bus_arbiter #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .reset(reset), .phi2(phi2),
      .r0_req(r0_req), .r0_we(r0_we), .r0_rs(r0_rs), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
      .r0_ack(rr_r0_ack), .r0_rdata(rr_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_rs(r1_rs), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
      .r1_ack(rr_r1_ack), .r1_rdata(rr_r1_rdata),
      .cia_cs_n(rr_cs_n), .cia_rw(rr_rw), .cia_rs(rr_rs), .cia_wdata(rr_wdata),
      .cia_rdata(cia_out)
   );

   cia_bus_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .phi2(phi2),
      .r0_req(r0_req), .r0_we(r0_we), .r0_rs(r0_rs), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
      .r0_ack(fp_r0_ack), .r0_rdata(fp_r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_rs(r1_rs), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
      .r1_ack(fp_r1_ack), .r1_rdata(fp_r1_rdata),
      .cia_cs_n(fp_cs_n), .cia_rw(fp_rw), .cia_rs(fp_rs), .cia_wdata(fp_wdata),
      .cia_rdata(cia_out)
   );

   always #5 clk = ~clk;

   // phi2: one-clk strobe every 4 clks, changed just after the edge
   initial begin
      int pcnt;
      pcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         pcnt = (pcnt + 1) % 4;
         phi2 = (pcnt == 0);
      end
   end

   int   cyc = 0;
   logic phi2_q = 1'b0;
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      phi2_q <= phi2;
   end

   // CIA register-file model driven by the observed instance
   logic [7:0] cia_regs [16];
   logic       pre_en = 1'b0;
   logic [3:0] pre_rs = '0;
   logic [7:0] pre_val = '0;
   always @(posedge clk) begin
      if (pre_en) begin
         cia_regs[pre_rs] <= pre_val;
      end else if (s_cs_n == 1'b0) begin
         if (!s_rw) cia_regs[s_rs] <= s_wdata;
         cia_out <= cia_regs[s_rs];
      end
   end

   typedef struct packed {
      logic       id;
      logic [7:0] rdata;
   } exp_t;
   exp_t sb[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on every ack and checks bus timing
   initial begin
      logic cs_prev;
      int   fall_cyc;
      exp_t e;
      cs_prev  = 1'b1;
      fall_cyc = 0;
      forever begin
         @(negedge clk);
         if (s_cs_n === 1'b0 && cs_prev === 1'b1) begin
            check("cs_fall_on_phi2", {31'b0, phi2_q}, 32'd1);
            fall_cyc = cyc;
         end
         if (s_cs_n === 1'b1 && cs_prev === 1'b0)
            check("cs_low_width", cyc - fall_cyc, 32'd1);
         if (s_r0_ack || s_r1_ack) begin
            check("ack_exclusive", {31'b0, s_r0_ack & s_r1_ack}, 32'd0);
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ack: got r0_ack=%0b r1_ack=%0b, expected no ack", s_r0_ack, s_r1_ack);
            end else begin
               e = sb.pop_front();
               check("ack_id", {31'b0, s_r1_ack}, {31'b0, e.id});
               check("ack_rdata", {24'b0, (s_r1_ack ? s_r1_rdata : s_r0_rdata)}, {24'b0, e.rdata});
               check("ack_latency", cyc - fall_cyc, 32'd2);
            end
         end
         cs_prev = s_cs_n;
      end
   end

   task automatic push(input logic id, input logic [7:0] rd);
      exp_t e;
      e.id    = id;
      e.rdata = rd;
      sb.push_back(e);
   endtask

   // called just after a posedge; returns just after the edge following ack
   task automatic access(input logic id, input logic we, input logic [3:0] rs,
                         input logic [7:0] wd, input logic lock, input logic drop);
      bit got;
      got = 1'b0;
      if (id == 1'b0) begin
         r0_we = we; r0_rs = rs; r0_wdata = wd; r0_lock = lock; r0_req = 1'b1;
      end else begin
         r1_we = we; r1_rs = rs; r1_wdata = wd; r1_lock = lock; r1_req = 1'b1;
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (id ? s_r1_ack : s_r0_ack) begin
            got = 1'b1;
            break;
         end
      end
      check("access_ack_seen", {31'b0, got}, 32'd1);
      @(posedge clk);
      #1;
      if (drop) begin
         if (id == 1'b0) r0_req = 1'b0;
         else            r1_req = 1'b0;
      end
   endtask

   task automatic preload(input logic [3:0] rs, input logic [7:0] v);
      pre_rs  = rs;
      pre_val = v;
      pre_en  = 1'b1;
      @(posedge clk);
      #1;
      pre_en  = 1'b0;
   endtask

   task automatic do_reset();
      r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0; r1_lock = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check(nm, sb.size(), 32'd0);
   endtask

   task automatic wait_cs_fall();
      for (int i = 0; i < 100 && s_cs_n !== 1'b0; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      check("rst_cs_n", {31'b0, s_cs_n}, 32'd1);
      check("rst_rw", {31'b0, s_rw}, 32'd1);
      check("rst_rs", {28'b0, s_rs}, 32'd0);
      check("rst_wdata", {24'b0, s_wdata}, 32'd0);
      check("rst_acks", {30'b0, s_r1_ack, s_r0_ack}, 32'd0);
      check("rst_rdata", {16'b0, s_r1_rdata, s_r0_rdata}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      preload(CIA_DDRA, 8'h5A);
      preload(CIA_ICR, 8'h81);

      // 1: single r0 read of DDRA
      push(REQ_CPU, 8'h5A);
      access(REQ_CPU, 1'b0, CIA_DDRA, 8'h00, 1'b0, 1'b1);
      drain("s1_drain");
      check("s1_r1_rdata", {24'b0, s_r1_rdata}, 32'd0);

      // 2: simultaneous writes, round robin from fresh reset
      do_reset();
      push(REQ_CPU, 8'h00);
      push(REQ_HOST, 8'h00);
      fork
         access(REQ_CPU, 1'b1, CIA_DDRA, 8'hA5, 1'b0, 1'b1);
         access(REQ_HOST, 1'b1, CIA_DDRB, 8'h3C, 1'b0, 1'b1);
      join
      drain("s2_drain");
      check("s2_ddra", {24'b0, cia_regs[2]}, 32'hA5);
      check("s2_ddrb", {24'b0, cia_regs[3]}, 32'h3C);

      // 3: fixed priority, r1 held while r0 does three back-to-back reads
      sel = 1'b1;
      do_reset();
      push(REQ_CPU, 8'hA5);
      push(REQ_CPU, 8'h3C);
      push(REQ_CPU, 8'hA5);
      push(REQ_HOST, 8'h3C);
      fork
         begin
            access(REQ_CPU, 1'b0, CIA_DDRA, 8'h00, 1'b0, 1'b0);
            access(REQ_CPU, 1'b0, CIA_DDRB, 8'h00, 1'b0, 1'b0);
            access(REQ_CPU, 1'b0, CIA_DDRA, 8'h00, 1'b0, 1'b1);
         end
         access(REQ_HOST, 1'b0, CIA_DDRB, 8'h00, 1'b0, 1'b1);
      join
      drain("s3_drain");

      // 4: r1 locked ICR read then unlocked write beats a waiting r0
      sel = 1'b0;
      do_reset();
      push(REQ_HOST, 8'h81);
      push(REQ_HOST, 8'h81);
      push(REQ_CPU, 8'h77);
      fork
         begin
            access(REQ_HOST, 1'b0, CIA_ICR, 8'h00, 1'b1, 1'b0);
            access(REQ_HOST, 1'b1, CIA_DDRB, 8'h77, 1'b0, 1'b1);
         end
         begin
            wait_cs_fall();
            @(posedge clk);
            #1;
            access(REQ_CPU, 1'b0, CIA_DDRB, 8'h00, 1'b0, 1'b1);
         end
      join
      drain("s4_drain");
      check("s4_ddrb", {24'b0, cia_regs[3]}, 32'h77);

      // 5: reset one clk after cs_n falls aborts the access
      push(REQ_CPU, 8'h81);
      access(REQ_CPU, 1'b0, CIA_ICR, 8'h00, 1'b0, 1'b1);
      drain("s5_pre_drain");
      r0_we = 1'b0; r0_rs = CIA_DDRA; r0_lock = 1'b0; r0_req = 1'b1;
      wait_cs_fall();
      reset = 1'b1;
      @(negedge clk);
      check("s5_cs_n", {31'b0, s_cs_n}, 32'd1);
      check("s5_ack", {30'b0, s_r1_ack, s_r0_ack}, 32'd0);
      check("s5_rdata", {24'b0, s_r0_rdata}, 32'd0);
      check("s5_rs", {28'b0, s_rs}, 32'd0);
      reset  = 1'b0;
      r0_req = 1'b0;
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      push(REQ_CPU, 8'hA5);
      access(REQ_CPU, 1'b0, CIA_DDRA, 8'h00, 1'b0, 1'b1);
      drain("s5_drain");

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
